// File: rtl/idi_arbiter_if.sv
// Bundle of requester-side and sink-side signals around the IDI arbiter.
//
// Handshake: a requester raises req_valid[i] with req_is_write/req_addr/req_wdata
// and holds them stable until req_ready[i] pulses for one cycle (req_err[i] and
// req_rdata qualify that same cycle). Dropping req_valid[i] before req_ready[i]
// aborts the request. Toward the sink, m_valid stays high with stable fields
// until a cycle with m_ready=1 completes the transfer; m_rdata is sampled only
// in that cycle.
interface idi_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_is_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_err;
    logic [DATA_W-1:0]       req_rdata;
    logic                    m_valid;
    logic                    m_is_write;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic [DATA_W-1:0]       m_rdata;
    logic                    m_ready;

    // Arbiter side: consumes requests and sink responses, drives the rest.
    modport master (
        input  req_valid, req_is_write, req_addr, req_wdata, m_rdata, m_ready,
        output req_ready, req_err, req_rdata, m_valid, m_is_write, m_addr, m_wdata
    );

    // Environment side: requesters plus the sink.
    modport slave (
        output req_valid, req_is_write, req_addr, req_wdata, m_rdata, m_ready,
        input  req_ready, req_err, req_rdata, m_valid, m_is_write, m_addr, m_wdata
    );
endinterface

// File: rtl/idi_arbiter.sv
// Round-robin arbiter sharing one IDI sink port among N_REQ requesters.
// One transaction in flight at a time; an IDLE cycle separates grants.
// A BUSY-cycle counter aborts a stalled transaction with an error strobe.
module idi_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int ADDR_W      = 64,
    parameter  int DATA_W      = 32,
    parameter  int TIMEOUT_CYC = 255,
    localparam int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    idi_arbiter_if.master    bus,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx,
    output logic             dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value seen in the last permitted BUSY cycle (counter starts at 0).
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              found;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Round-robin choice: first requesting index upward from last_q+1, wrapping.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Route the granted requester's fields toward the sink.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_write = bus.req_is_write[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output decode; completion beats abort, abort beats timeout.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        bus.m_valid    = 1'b0;
        bus.m_is_write = 1'b0;
        bus.m_addr     = '0;
        bus.m_wdata    = '0;
        bus.req_ready  = '0;
        bus.req_err    = '0;
        bus.req_rdata  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.m_valid    = 1'b1;
                bus.m_is_write = sel_write;
                bus.m_addr     = sel_addr;
                bus.m_wdata    = sel_wdata;
                if (bus.m_ready) begin
                    bus.req_ready[grant_q] = 1'b1;
                    bus.req_rdata          = bus.m_rdata;
                    last_d                 = grant_q;
                    state_d                = IDLE;
                end else if (!bus.req_valid[grant_q]) begin
                    // Requester withdrew: no strobe, fairness pointer untouched.
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    bus.req_ready[grant_q] = 1'b1;
                    bus.req_err[grant_q]   = 1'b1;
                    last_d                 = grant_q;
                    state_d                = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q == BUSY);
    assign grant_idx   = grant_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/idi_arbiter.md
IDI_ARBITER -- requirements
Module: idi_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters sharing one IDI sink port.
REQ-002 SHALL provide parameter ADDR_W, default 64, address width.
REQ-003 SHALL provide parameter DATA_W, default 32, read and write data width.
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 255, maximum BUSY cycles before a transaction is aborted; legal range 1..65535.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, N_REQ bits: per-requester request.
REQ-008 SHALL have port req_is_write, input, N_REQ bits: per-requester 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, N_REQ*ADDR_W bits: packed per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata, input, N_REQ*DATA_W bits: packed per-requester write data.
REQ-011 SHALL have port req_ready, output, N_REQ bits: per-requester completion strobe.
REQ-012 SHALL have port req_err, output, N_REQ bits: per-requester timeout flag, valid with req_ready.
REQ-013 SHALL have port req_rdata, output, DATA_W bits: read data, shared, valid with req_ready.
REQ-014 SHALL have port m_valid, output, 1 bit: request to the sink.
REQ-015 SHALL have port m_is_write, output, 1 bit: request type to the sink.
REQ-016 SHALL have port m_addr, output, ADDR_W bits: address to the sink.
REQ-017 SHALL have port m_wdata, output, DATA_W bits: write data to the sink.
REQ-018 SHALL have port m_rdata, input, DATA_W bits: read data from the sink.
REQ-019 SHALL have port m_ready, input, 1 bit: sink completion.
REQ-020 SHALL have port busy, output, 1 bit: high in BUSY.
REQ-021 SHALL have port grant_idx, output, $clog2(N_REQ) bits: index of the current or last granted requester.

Function
REQ-022 SHALL implement two states, IDLE and BUSY.
REQ-023 In IDLE, with any req_valid bit high, SHALL select the first high bit searching upward from (last_grant+1) mod N_REQ, register it into grant_idx, and enter BUSY on the next edge; this gives 1 cycle request-to-m_valid latency.
REQ-024 In BUSY, SHALL drive m_valid=1 and, combinationally, m_is_write/m_addr/m_wdata from requester grant_idx; the requester holds its fields stable until its req_ready.
REQ-025 In BUSY with m_ready=1, SHALL pulse req_ready[grant_idx]=1 for that cycle, drive req_rdata=m_rdata, update last_grant=grant_idx, and return to IDLE.
REQ-026 In IDLE, m_valid SHALL be 0, req_ready/req_err SHALL be all 0, and req_rdata SHALL be 0.
REQ-027 Sustained throughput SHALL be at most one transaction per 2 cycles (IDLE cycle between grants).
REQ-028 SHALL count cycles in BUSY with a 16-bit counter cleared on BUSY entry.
REQ-029 When the counter reaches TIMEOUT_CYC without m_ready, SHALL pulse req_ready[grant_idx]=1 and req_err[grant_idx]=1 with req_rdata=0, drop m_valid, and return to IDLE.
REQ-030 If m_ready and the timeout occur in the same cycle, completion SHALL win: req_err=0.
REQ-031 If req_valid[grant_idx] falls during BUSY without m_ready (requester abort), SHALL return to IDLE without pulsing req_ready and leave last_grant unchanged.
REQ-032 m_ready received in IDLE SHALL be ignored.
REQ-033 Only the granted requester's req_ready/req_err bits SHALL ever be high, and at most one bit per cycle.

Reset
REQ-034 While rst=1, SHALL force IDLE, last_grant=N_REQ-1, grant_idx=0, timeout counter=0, and all outputs to 0, asynchronously.
REQ-035 Reset asserted in BUSY SHALL drop m_valid immediately without any req_ready pulse.

Verification
REQ-036 Single write: req_valid=0001, write, addr 0x100, wdata 0xDEADBEEF, m_ready 2 cycles after m_valid -> m_addr=0x100, m_wdata=0xDEADBEEF, req_ready=0001 once, busy for 3 cycles.
REQ-037 Read: requester 2 reads addr 0x100, m_rdata=0xDEADBEEF with m_ready -> req_ready=0100, req_rdata=0xDEADBEEF in that cycle.
REQ-038 Round-robin: req_valid=1111 held, m_ready=1 every BUSY cycle -> grant order 0,1,2,3,0; one req_ready pulse per 2 cycles.
REQ-039 Timeout: TIMEOUT_CYC=4, m_ready held 0 -> req_ready and req_err on requester 0 after 4 BUSY cycles, req_rdata=0, m_valid low next cycle.
REQ-040 Reset mid-BUSY, plus abort: rst pulsed while BUSY -> m_valid=0 with no req_ready; after reset, grant goes to requester 0. Separately, drop req_valid mid-BUSY -> IDLE, no pulse.
